wb_mem_responder: RTL and testbench
===================================

# wb_mem_responder

Synthesizable Wishbone B3 slave memory that answers the Ethernet MAC's DMA master port (`m_wb_*`). It holds TX buffer data that the MAC fetches and takes RX buffer data that the MAC writes back. It supports classic and incrementing-burst cycles (CTI/BTE), programmable wait states and error injection. It sits in the testbench environment as the far end of the MAC master interface; the bus-monitor structs capture its traffic.

## Interface
Parameters:
- `DATA_WIDTH`, 32, data bus width
- `ADDR_WIDTH`, 32, byte address width
- `SEL_WIDTH`, 4, byte selects (`DATA_WIDTH/8`)
- `MEM_DEPTH_LOG2`, 10, log2 of memory depth in words (1024 words)
- `BASE_ADDR`, 32'h0000_0000, byte address of word 0

Ports:
- `wb_clk_i`  in  1  clock
- `wb_rst_i`  in  1  reset; synchronous, active-high
- `m_wb_adr_i`  in  ADDR_WIDTH  byte address from the MAC master
- `m_wb_sel_i`  in  SEL_WIDTH  byte enables
- `m_wb_we_i`  in  1  1=write, 0=read
- `m_wb_dat_i`  in  DATA_WIDTH  write data from master
- `m_wb_dat_o`  out  DATA_WIDTH  read data to master
- `m_wb_cyc_i`, `m_wb_stb_i`  in  1  cycle, strobe
- `m_wb_cti_i`  in  3  cycle type: 000 classic, 010 incrementing burst, 111 end of burst
- `m_wb_bte_i`  in  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16
- `m_wb_ack_o`  out  1  acknowledge
- `m_wb_err_o`  out  1  error
- `wait_cfg_i`  in  4  wait states inserted before the first beat of each access
- `err_inject_i`  in  1  force ERR on the next beat started
- `beat_cnt_o`  out  16  acked beats; saturates at 16'hFFFF

## Operation
- FSM states: IDLE, WAIT, BURST, ERR.
- **IDLE**
  - `cyc&stb&!ack` starts an access. The beat address is `(adr-BASE_ADDR)>>2`, latched into the burst address counter.
  - If `wait_cfg_i`≠0, load the wait counter and go to WAIT.
  - Otherwise respond next cycle.
- **WAIT**
  - Decrement the counter. At 0, respond next cycle.
  - If `cyc` drops, return to IDLE.
- **Response (ack or err, one cycle)**
  - Out-of-range address (word index ≥ 2^MEM_DEPTH_LOG2, or adr<BASE_ADDR): assert `err`, go to ERR.
  - `err_inject_i` sampled high at access start: assert `err`, go to ERR.
  - Otherwise assert `ack`.
    - Read: `m_wb_dat_o` = mem word, registered with `ack`.
    - Write: bytes with `sel` set are written on the ack edge. Other bytes keep their value.
- **Classic (cti=000 or 111 outside a burst)**
  - One ack, then IDLE.
  - `ack` is deasserted for at least one cycle between classic accesses.
- **BURST**
  - Entered after the first acked beat when `cti`=010.
  - Subsequent beats ack every cycle with zero wait states while `stb` is high.
  - The address advances one word per ack. For bte≠00 it wraps inside the aligned 4/8/16-word block, so only the low 2/3/4 index bits change.
  - Stops after acking a beat presented with `cti`=111, then IDLE.
- **Master pauses**
  - `stb` low while `cyc` is high in BURST: hold the address, no ack, resume when `stb` rises.
  - `cyc` low in any state: IDLE next cycle, no further ack/err.
- **Errors inside a burst**
  - A burst beat whose address leaves the memory range gets `err` instead of `ack`, then goes to ERR.
  - ERR holds `err` low, waits for `cyc` low, then goes to IDLE.
- **Invariants**
  - `ack` and `err` are never high together.
  - `beat_cnt_o` increments on each `ack` only.

## Timing
- Reset values: `m_wb_ack_o`=0, `m_wb_err_o`=0, `m_wb_dat_o`=0, `beat_cnt_o`=0, FSM=IDLE, wait/burst counters=0.
- Memory contents are not cleared by reset.
- Reset mid-burst: outputs go to reset values next edge. An in-flight write beat not yet acked is not written.
- Request sampled at edge 0 with `wait_cfg_i`=N: `ack`/`err` is high in cycle N+1.
- Burst: beats k=1.. acked in cycles N+k while `stb` stays high.
- All outputs are registered. There are no combinational input-to-output paths.
- Address, data and sel for a burst beat are used in the cycle its ack is registered. The next-beat address is computed combinationally from the counter.

## Structure
- Package `wb_resp_pkg`:
  - FSM state enum
  - CTI constants CLASSIC/INCR/EOB
  - BTE constants LINEAR/WRAP4/WRAP8/WRAP16
  - wrap-mask function
- Sub-module `wb_resp_ram`: single-port, byte-enabled word RAM with synchronous write and registered read, depth 2^MEM_DEPTH_LOG2.
- FSM and counters live in `wb_mem_responder`.

## Test plan
- **Classic write/read:** write 32'hDEADBEEF at 0x10 with sel=1111, wait_cfg=0, then read 0x10 → ack in cycle 1 of each access, read data 32'hDEADBEEF, `beat_cnt_o`=2.
- **Byte enables and wait states:** write 32'h11223344 to 0x20, then write 32'hAABBCCDD with sel=0101 and wait_cfg=3, then read → ack 4 cycles after request, data 32'h11BB33DD.
- **Wrap4 burst read:** from 0x38 with bte=01, 4 beats, last beat cti=111 → words at 0x38, 0x3C, 0x30, 0x34 on consecutive acks, ack low afterwards.
- **Linear burst past end:** 1024-word memory, start 0xFF8, 4 beats → ack, ack, err at 0x1000. `err` held low until `cyc` drops, then IDLE.
- **Pause and abort:** pause `stb` for 2 cycles mid-burst → no ack during the pause and the address is held. Drop `cyc` mid-burst → no ack next cycle, FSM in IDLE.
- **Error inject and reset:** `err_inject_i` on a write to 0x40 → err, memory unchanged, `beat_cnt_o` unchanged. Assert `wb_rst_i` during a 3-wait access → ack/err stay 0, counters 0.

Source files
------------

// File: rtl/wb_resp_pkg.sv
// Shared types and constants for the Wishbone memory responder.
//   resp_state_e : responder FSM states
//   Cti*         : Wishbone cycle-type identifiers
//   Bte*         : Wishbone burst-type extensions
//   wrap_mask()  : low word-index bits that may change during a wrapping burst
package wb_resp_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StBurst,
    StErr
  } resp_state_e;

  localparam logic [2:0] CtiClassic = 3'b000;
  localparam logic [2:0] CtiIncr    = 3'b010;
  localparam logic [2:0] CtiEob     = 3'b111;

  localparam logic [1:0] BteLinear = 2'b00;
  localparam logic [1:0] BteWrap4  = 2'b01;
  localparam logic [1:0] BteWrap8  = 2'b10;
  localparam logic [1:0] BteWrap16 = 2'b11;

  // Zero for linear bursts: the caller increments the whole index instead.
  function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
    logic [3:0] mask;
    unique case (bte)
      BteLinear: mask = 4'b0000;
      BteWrap4:  mask = 4'b0011;
      BteWrap8:  mask = 4'b0111;
      BteWrap16: mask = 4'b1111;
      default:   mask = 4'b0000;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/wb_resp_ram.sv
// Single-port byte-enabled word RAM, synchronous write, registered read.
//   clk, rst : clock; rst clears only the read-data register, never the array
//   wr_en    : write the bytes selected by sel at addr
//   rd_en    : load mem[addr] into rdata
//   sel      : byte enables
//   addr     : word index
//   wdata    : write data
//   rdata    : registered read data
module wb_resp_ram #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SEL_WIDTH  = 4,
  parameter int unsigned DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [SEL_WIDTH-1:0]  sel,
  input  logic [DEPTH_LOG2-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [2**DEPTH_LOG2];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned b = 0; b < SEL_WIDTH; b++) begin
        if (sel[b]) begin
          mem[addr][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (rd_en) begin
      rdata_q <= mem[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_mem_responder.sv
// Wishbone B3 slave memory answering the MAC DMA master port.
// Supports classic and incrementing bursts (linear/wrap4/8/16), programmable
// wait states before the first beat, and one-shot error injection.
//   wb_clk_i, wb_rst_i        : clock, synchronous active-high reset
//   m_wb_adr/sel/we/dat_i     : master address, byte enables, direction, write data
//   m_wb_cyc/stb/cti/bte_i    : master cycle control
//   m_wb_dat_o/ack_o/err_o    : registered read data and termination
//   wait_cfg_i                : wait states before the first beat of an access
//   err_inject_i              : sampled at access start; forces ERR on that beat
//   beat_cnt_o                : saturating count of acked beats
module wb_mem_responder
  import wb_resp_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH     = 32,
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter int unsigned           SEL_WIDTH      = 4,
  parameter int unsigned           MEM_DEPTH_LOG2 = 10,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = '0
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [ADDR_WIDTH-1:0] m_wb_adr_i,
  input  logic [SEL_WIDTH-1:0]  m_wb_sel_i,
  input  logic                  m_wb_we_i,
  input  logic [DATA_WIDTH-1:0] m_wb_dat_i,
  output logic [DATA_WIDTH-1:0] m_wb_dat_o,
  input  logic                  m_wb_cyc_i,
  input  logic                  m_wb_stb_i,
  input  logic [2:0]            m_wb_cti_i,
  input  logic [1:0]            m_wb_bte_i,
  output logic                  m_wb_ack_o,
  output logic                  m_wb_err_o,
  input  logic [3:0]            wait_cfg_i,
  input  logic                  err_inject_i,
  output logic [15:0]           beat_cnt_o
);

  resp_state_e           state_q, state_d;
  // Word index relative to BASE_ADDR; kept full width so running off the end
  // of the array is detectable rather than silently wrapping.
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  oor_q, oor_d;   // start address was below BASE_ADDR
  logic                  inj_q, inj_d;
  logic [3:0]            wait_q, wait_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic [15:0]           beat_cnt_q, beat_cnt_d;

  logic [ADDR_WIDTH-1:0] byte_off;
  logic [ADDR_WIDTH-1:0] wrap_bits;
  logic [ADDR_WIDTH-1:0] addr_inc;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  in_range;
  logic                  beat;
  logic                  beat_bad;
  logic                  ram_we;
  logic                  ram_re;

  assign byte_off  = m_wb_adr_i - BASE_ADDR;
  assign wrap_bits = ADDR_WIDTH'(wrap_mask(m_wb_bte_i));
  assign addr_inc  = addr_q + 1'b1;
  // Wrapping bursts only advance the low index bits inside the aligned block.
  assign next_addr = (m_wb_bte_i == BteLinear) ? addr_inc
                                                : (addr_q & ~wrap_bits) | (addr_inc & wrap_bits);
  assign in_range  = !oor_q && ((addr_q >> MEM_DEPTH_LOG2) == '0);
  // Injection applies only to the first beat, which is always issued from StWait.
  assign beat_bad  = !in_range || (inj_q && (state_q == StWait));

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    oor_d      = oor_q;
    inj_d      = inj_q;
    wait_d     = wait_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    beat       = 1'b0;

    unique case (state_q)
      StIdle: begin
        // ack_q gate keeps a one-cycle gap between back-to-back classic cycles.
        if (m_wb_cyc_i && m_wb_stb_i && !ack_q) begin
          addr_d  = byte_off >> 2;
          oor_d   = (m_wb_adr_i < BASE_ADDR);
          inj_d   = err_inject_i;
          wait_d  = wait_cfg_i;
          state_d = StWait;
        end
      end
      StWait: begin
        if (!m_wb_cyc_i) begin
          state_d = StIdle;
        end else if (wait_q != 4'd0) begin
          wait_d = wait_q - 4'd1;
        end else begin
          beat = m_wb_stb_i;
        end
      end
      StBurst: begin
        if (!m_wb_cyc_i) begin
          state_d = StIdle;
        end else begin
          beat = m_wb_stb_i;
        end
      end
      StErr: begin
        if (!m_wb_cyc_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (beat) begin
      if (beat_bad) begin
        err_d   = 1'b1;
        state_d = StErr;
      end else begin
        ack_d  = 1'b1;
        addr_d = next_addr;
        case (m_wb_cti_i)
          CtiIncr:            state_d = StBurst;
          CtiClassic, CtiEob: state_d = StIdle;
          default:            state_d = StIdle;
        endcase
      end
    end

    beat_cnt_d = beat_cnt_q;
    if (ack_d && (beat_cnt_q != 16'hFFFF)) begin
      beat_cnt_d = beat_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      inj_q      <= 1'b0;
      wait_q     <= 4'd0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      beat_cnt_q <= 16'd0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      inj_q      <= inj_d;
      wait_q     <= wait_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  // Write lands on the ack edge; reset suppresses an in-flight write.
  assign ram_we = beat && !beat_bad && m_wb_we_i && !wb_rst_i;
  assign ram_re = beat && !beat_bad && !m_wb_we_i;

  wb_resp_ram #(
    .DATA_WIDTH(DATA_WIDTH),
    .SEL_WIDTH (SEL_WIDTH),
    .DEPTH_LOG2(MEM_DEPTH_LOG2)
  ) u_ram (
    .clk  (wb_clk_i),
    .rst  (wb_rst_i),
    .wr_en(ram_we),
    .rd_en(ram_re),
    .sel  (m_wb_sel_i),
    .addr (addr_q[MEM_DEPTH_LOG2-1:0]),
    .wdata(m_wb_dat_i),
    .rdata(m_wb_dat_o)
  );

  assign m_wb_ack_o = ack_q;
  assign m_wb_err_o = err_q;
  assign beat_cnt_o = beat_cnt_q;

endmodule

// File: tb/tb_wb_mem_responder.sv
// Self-checking bench for wb_mem_responder: a directed vector table, hand-written
// burst/pause/abort/reset sequences and randomized accesses checked against a
// word-array memory model.
module tb_wb_mem_responder;

  localparam int Depth = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] adr;
  logic [3:0]  sel;
  logic        we;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic [3:0]  wait_cfg;
  logic        inject;
  logic [15:0] beat_cnt;

  always #5 clk = ~clk;

  wb_mem_responder dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .m_wb_adr_i  (adr),
    .m_wb_sel_i  (sel),
    .m_wb_we_i   (we),
    .m_wb_dat_i  (dat_w),
    .m_wb_dat_o  (dat_r),
    .m_wb_cyc_i  (cyc),
    .m_wb_stb_i  (stb),
    .m_wb_cti_i  (cti),
    .m_wb_bte_i  (bte),
    .m_wb_ack_o  (ack),
    .m_wb_err_o  (err),
    .wait_cfg_i  (wait_cfg),
    .err_inject_i(inject),
    .beat_cnt_o  (beat_cnt)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int          exp_beats = 0;
  logic        mon_en = 1'b0;
  logic [31:0] model [Depth];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h want %h", name, got, want);
  endtask

  always @(negedge clk) begin
    if (mon_en) check("ack_err_exclusive", {31'b0, ack & err}, 32'd0);
  end

  // Waits (bounded) for ack or err; waits = posedges elapsed since the request was driven.
  task automatic wait_resp(output logic got_ack, output logic got_err, output int waits);
    waits   = 0;
    got_ack = 1'b0;
    got_err = 1'b0;
    while (waits < 40) begin
      @(posedge clk);
      #1;
      waits++;
      if (ack || err) begin
        got_ack = ack;
        got_err = err;
        return;
      end
    end
    n_checks++;
    $display("FAIL resp_timeout: got no ack/err after %0d cycles, want a response", waits);
  endtask

  task automatic end_cycle();
    cyc    = 1'b0;
    stb    = 1'b0;
    inject = 1'b0;
    @(posedge clk);
    #1;
    check("idle_ack", {31'b0, ack}, 32'd0);
    check("idle_err", {31'b0, err}, 32'd0);
  endtask

  // One access of nb beats (nb==1 is classic). Expected results come from the
  // word model: beat k address is start+k (linear) or wraps inside the aligned block.
  task automatic access(input logic w, input logic [31:0] a, input logic [3:0] s,
                        input logic [1:0] b, input int nb, input logic [3:0] ws,
                        input logic inj, input int pause_after, input int abort_after);
    int          base_idx, wsize, idx, waits;
    logic        ga, ge, exp_err;
    logic [31:0] wd;
    base_idx = int'(a >> 2);
    wsize    = (b == 2'd0) ? 0 : (b == 2'd1) ? 4 : (b == 2'd2) ? 8 : 16;
    wait_cfg = ws;
    inject   = inj;
    we       = w;
    sel      = s;
    bte      = b;
    cyc      = 1'b1;
    stb      = 1'b1;
    for (int k = 0; k < nb; k++) begin
      if (wsize == 0) idx = base_idx + k;
      else idx = (base_idx / wsize) * wsize + (base_idx % wsize + k) % wsize;
      wd    = $urandom;
      dat_w = wd;
      adr   = 32'(idx) << 2;
      cti   = (nb == 1) ? 3'b000 : (k == nb - 1) ? 3'b111 : 3'b010;
      wait_resp(ga, ge, waits);
      exp_err = (inj && k == 0) || (idx >= Depth);
      check("beat_ack", {31'b0, ga}, {31'b0, !exp_err});
      check("beat_err", {31'b0, ge}, {31'b0, exp_err});
      check("beat_latency", waits, (k == 0) ? int'(ws) + 2 : 1);
      if (exp_err) begin
        check("err_beat_cnt", {16'b0, beat_cnt}, exp_beats);
        // Responder must stay silent until cyc drops.
        repeat (2) begin
          @(posedge clk);
          #1;
          check("errstate_ack", {31'b0, ack}, 32'd0);
          check("errstate_err", {31'b0, err}, 32'd0);
        end
        break;
      end
      if (w) begin
        for (int j = 0; j < 4; j++) if (s[j]) model[idx][8*j +: 8] = wd[8*j +: 8];
      end else begin
        check("read_data", dat_r, model[idx]);
      end
      if (exp_beats < 65535) exp_beats++;
      check("beat_cnt", {16'b0, beat_cnt}, exp_beats);
      if (k == abort_after && k < nb - 1) begin
        cyc = 1'b0;
        stb = 1'b0;
        @(posedge clk);
        #1;
        check("abort_ack", {31'b0, ack}, 32'd0);
        check("abort_err", {31'b0, err}, 32'd0);
        break;
      end
      if (k == pause_after && k < nb - 1) begin
        stb = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
          check("pause_ack", {31'b0, ack}, 32'd0);
        end
        stb = 1'b1;
      end
    end
    end_cycle();
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [3:0]  s;
    logic [31:0] d;
    logic [3:0]  ws;
    logic        inj;
    logic        e_ack;
    logic [31:0] e_rd;
    int          e_lat;
    int          e_cnt;
  } vec_t;

  vec_t vecs[13];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    logic ga, ge;
    int   waits;

    rst = 1'b1; adr = '0; sel = '0; we = 1'b0; dat_w = '0; cyc = 1'b0; stb = 1'b0;
    cti = '0; bte = '0; wait_cfg = '0; inject = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", {31'b0, ack}, 32'd0);
    check("reset_err", {31'b0, err}, 32'd0);
    check("reset_dat", dat_r, 32'd0);
    check("reset_beat_cnt", {16'b0, beat_cnt}, 32'd0);
    rst    = 1'b0;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    //           w     adr          sel    data          ws    inj   ack   rdata        lat cnt
    vecs[0]  = '{1'b1, 32'h10,      4'hF, 32'hDEADBEEF, 4'd0, 1'b0, 1'b1, 32'h0,        1, 1};
    vecs[1]  = '{1'b0, 32'h10,      4'hF, 32'h0,        4'd0, 1'b0, 1'b1, 32'hDEADBEEF, 1, 2};
    vecs[2]  = '{1'b1, 32'h20,      4'hF, 32'h11223344, 4'd0, 1'b0, 1'b1, 32'h0,        1, 3};
    vecs[3]  = '{1'b1, 32'h20,      4'h5, 32'hAABBCCDD, 4'd3, 1'b0, 1'b1, 32'h0,        4, 4};
    vecs[4]  = '{1'b0, 32'h20,      4'hF, 32'h0,        4'd0, 1'b0, 1'b1, 32'h11BB33DD, 1, 5};
    vecs[5]  = '{1'b1, 32'h40,      4'hF, 32'hCAFEF00D, 4'd1, 1'b0, 1'b1, 32'h0,        2, 6};
    vecs[6]  = '{1'b1, 32'h40,      4'hF, 32'h01234567, 4'd0, 1'b1, 1'b0, 32'h0,        1, 6};
    vecs[7]  = '{1'b0, 32'h40,      4'hF, 32'h0,        4'd2, 1'b0, 1'b1, 32'hCAFEF00D, 3, 7};
    vecs[8]  = '{1'b0, 32'h1000,    4'hF, 32'h0,        4'd0, 1'b0, 1'b0, 32'h0,        1, 7};
    vecs[9]  = '{1'b1, 32'hFFC,     4'hF, 32'h5A5A5A5A, 4'd0, 1'b0, 1'b1, 32'h0,        1, 8};
    vecs[10] = '{1'b1, 32'hFFC,     4'h8, 32'hA5FFFFFF, 4'd0, 1'b0, 1'b1, 32'h0,        1, 9};
    vecs[11] = '{1'b0, 32'hFFC,     4'hF, 32'h0,        4'd1, 1'b0, 1'b1, 32'hA55A5A5A, 2, 10};
    vecs[12] = '{1'b0, 32'hFFFFFFFC, 4'hF, 32'h0,       4'd0, 1'b0, 1'b0, 32'h0,        1, 10};

    for (int i = 0; i < 13; i++) begin
      we = vecs[i].w; adr = vecs[i].a; sel = vecs[i].s; dat_w = vecs[i].d;
      wait_cfg = vecs[i].ws; inject = vecs[i].inj; cti = 3'b000; bte = 2'b00;
      cyc = 1'b1; stb = 1'b1;
      wait_resp(ga, ge, waits);
      check($sformatf("vec%0d_ack", i), {31'b0, ga}, {31'b0, vecs[i].e_ack});
      check($sformatf("vec%0d_err", i), {31'b0, ge}, {31'b0, !vecs[i].e_ack});
      check($sformatf("vec%0d_latency", i), waits - 1, vecs[i].e_lat);
      if (!vecs[i].w && vecs[i].e_ack) check($sformatf("vec%0d_rdata", i), dat_r, vecs[i].e_rd);
      check($sformatf("vec%0d_beat_cnt", i), {16'b0, beat_cnt}, vecs[i].e_cnt);
      if (vecs[i].e_ack) exp_beats++;
      if (vecs[i].w && vecs[i].e_ack) begin
        for (int j = 0; j < 4; j++) begin
          if (vecs[i].s[j]) model[int'(vecs[i].a >> 2)][8*j +: 8] = vecs[i].d[8*j +: 8];
        end
      end
      end_cycle();
    end

    // Fill the whole array with 16-beat linear write bursts so later reads are defined.
    for (int blk = 0; blk < Depth / 16; blk++) begin
      access(1'b1, 32'(blk * 64), 4'hF, 2'd0, 16, 4'd0, 1'b0, -1, -1);
    end

    access(1'b0, 32'h38,  4'hF, 2'd1, 4, 4'd0, 1'b0, -1, -1);  // wrap4: 38,3C,30,34
    access(1'b0, 32'hFF8, 4'hF, 2'd0, 4, 4'd0, 1'b0, -1, -1);  // ack, ack, err at 0x1000
    access(1'b0, 32'h100, 4'hF, 2'd0, 6, 4'd1, 1'b0, 2, -1);   // stb paused 2 cycles
    access(1'b0, 32'h200, 4'hF, 2'd2, 8, 4'd0, 1'b0, -1, 3);   // cyc dropped mid-burst
    access(1'b0, 32'h204, 4'hF, 2'd0, 1, 4'd0, 1'b0, -1, -1);  // back in IDLE: normal latency
    access(1'b1, 32'h2F0, 4'h6, 2'd3, 16, 4'd2, 1'b0, -1, -1); // wrap16 partial-byte write
    access(1'b0, 32'h2C4, 4'hF, 2'd0, 16, 4'd0, 1'b0, -1, -1);
    access(1'b1, 32'h300, 4'hF, 2'd0, 4, 4'd0, 1'b1, -1, -1);  // injected err on burst write
    access(1'b0, 32'h300, 4'hF, 2'd0, 4, 4'd0, 1'b0, -1, -1);

    // Reset in the middle of a 3-wait write: no response, counters cleared, no write.
    we = 1'b1; adr = 32'h80; sel = 4'hF; dat_w = 32'h0BADF00D; wait_cfg = 4'd3;
    cti = 3'b000; bte = 2'b00; cyc = 1'b1; stb = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; rst = 1'b0;
    check("rst_mid_ack", {31'b0, ack}, 32'd0);
    check("rst_mid_err", {31'b0, err}, 32'd0);
    check("rst_mid_beat_cnt", {16'b0, beat_cnt}, 32'd0);
    check("rst_mid_dat", dat_r, 32'd0);
    exp_beats = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("post_rst_ack", {31'b0, ack}, 32'd0);
    end
    access(1'b0, 32'h80, 4'hF, 2'd0, 1, 4'd0, 1'b0, -1, -1);

    for (int t = 0; t < 150; t++) begin
      logic       rw, inj;
      logic [1:0] b;
      logic [3:0] s, ws;
      int         nb, start, pa, ab;
      rw    = 1'($urandom_range(0, 1));
      b     = 2'($urandom_range(0, 3));
      ws    = 4'($urandom_range(0, 3));
      inj   = ($urandom_range(0, 11) == 0);
      nb    = ($urandom_range(0, 5) == 0) ? 16 : int'($urandom_range(1, 8));
      start = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1016, 1023))
                                          : int'($urandom_range(0, 1023));
      s     = rw ? 4'($urandom_range(1, 15)) : 4'hF;
      pa    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : -1;
      ab    = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 15)) : -1;
      access(rw, 32'(start) << 2, s, b, nb, ws, inj, pa, ab);
    end

    mon_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
